// File: rtl/ws2812_chain_if.sv
// Pixel-write and frame-control bundle for ws2812_chain.
// i_Brightness exists only when WS2812_BRIGHTNESS_EN is defined.
interface ws2812_chain_if #(
  parameter int NUM_LEDS = 8
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic          i_Wr_En;
  logic [AW-1:0] i_Wr_Addr;
  logic [23:0]   i_Wr_Data;
  logic          i_Start;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]    i_Brightness;
`endif
  logic          o_Led;
  logic          o_Ready;
  logic          o_Done;

`ifdef WS2812_BRIGHTNESS_EN
  modport master (output i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start, i_Brightness,
                  input  o_Led, o_Ready, o_Done);
  modport slave  (input  i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start, i_Brightness,
                  output o_Led, o_Ready, o_Done);
`else
  modport master (output i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start,
                  input  o_Led, o_Ready, o_Done);
  modport slave  (input  i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start,
                  output o_Led, o_Ready, o_Done);
`endif
endinterface

// File: rtl/ws2812_chain.sv
// WS2812 serial driver: NUM_LEDS x 24-bit GRB pixel store streamed MSB first.
// Define WS2812_BRIGHTNESS_EN to scale every colour byte by (i_Brightness+1)/256.
module ws2812_chain #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int NUM_LEDS        = 8,
  parameter int T0H_NS          = 400,
  parameter int T1H_NS          = 800,
  parameter int BIT_NS          = 1250,
  parameter int RESET_US        = 80
) (
  input logic           i_Clock,
  input logic           i_Reset,
  ws2812_chain_if.slave bus
);
  localparam int T0H_CYC   = int'(longint'(CLOCK_FREQUENCY) * longint'(T0H_NS) / 64'd1000000000);
  localparam int T1H_CYC   = int'(longint'(CLOCK_FREQUENCY) * longint'(T1H_NS) / 64'd1000000000);
  localparam int BIT_CYC   = int'(longint'(CLOCK_FREQUENCY) * longint'(BIT_NS) / 64'd1000000000);
  localparam int RESET_CYC = int'(longint'(CLOCK_FREQUENCY) * longint'(RESET_US) / 64'd1000000);

  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int LW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H_V    = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_V    = CW'(T1H_CYC);
  localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYC - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(NUM_LEDS - 1);

  if (T0H_CYC >= T1H_CYC || T1H_CYC >= BIT_CYC || NUM_LEDS < 1 || RESET_CYC < 1) begin : g_param_check
    $error("ws2812_chain: illegal timing or NUM_LEDS parameters");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, BIT = 2'd2, LATCH = 2'd3} state_t;

  state_t        r_State, w_State_Nx;
  logic [CW-1:0] r_Cyc, w_Cyc_Nx;
  logic [4:0]    r_Bit, w_Bit_Nx;
  logic [AW-1:0] r_Pix, w_Pix_Nx;
  logic [23:0]   r_Shift, w_Shift_Nx;
  logic [23:0]   r_Prefetch, w_Prefetch_Nx;
  logic [LW-1:0] r_Lat, w_Lat_Nx;
  logic          r_Led, w_Led_Nx;
  logic          r_Ready, w_Ready_Nx;
  logic          r_Done, w_Done_Nx;
  logic [23:0]   r_Mem [NUM_LEDS];
  logic [23:0]   w_Load_Pixel;
  logic [23:0]   w_Fetch_Pixel;
  logic [AW-1:0] w_Pix_Inc;
  logic          w_Addr_Ok;

  assign w_Pix_Inc = r_Pix + AW'(1'b1);
  assign w_Addr_Ok = ({1'b0, bus.i_Wr_Addr} < (AW+1)'(NUM_LEDS));

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] r_Bright;

  function automatic logic [23:0] scale_pixel(input logic [23:0] p, input logic [7:0] b);
    logic [15:0] prod;
    logic [23:0] res;
    res = 24'd0;
    for (int i = 0; i < 3; i++) begin
      prod = {8'd0, p[8*i +: 8]} * ({8'd0, b} + 16'd1);
      res[8*i +: 8] = prod[15:8];
    end
    return res;
  endfunction

  // Brightness is frozen for the whole frame once LOAD samples it.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Bright <= 8'd0;
    end else if (r_State == LOAD) begin
      r_Bright <= bus.i_Brightness;
    end else begin
      r_Bright <= r_Bright;
    end
  end

  assign w_Load_Pixel  = scale_pixel(r_Mem[{AW{1'b0}}], bus.i_Brightness);
  assign w_Fetch_Pixel = scale_pixel(r_Mem[w_Pix_Inc], r_Bright);
`else
  assign w_Load_Pixel  = r_Mem[{AW{1'b0}}];
  assign w_Fetch_Pixel = r_Mem[w_Pix_Inc];
`endif

  // Pixel store accepts writes in every state and deliberately has no reset.
  always_ff @(posedge i_Clock) begin
    if (bus.i_Wr_En && w_Addr_Ok) begin
      r_Mem[bus.i_Wr_Addr] <= bus.i_Wr_Data;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State    <= IDLE;
      r_Cyc      <= '0;
      r_Bit      <= 5'd0;
      r_Pix      <= '0;
      r_Shift    <= 24'd0;
      r_Prefetch <= 24'd0;
      r_Lat      <= '0;
      r_Led      <= 1'b0;
      r_Ready    <= 1'b1;
      r_Done     <= 1'b0;
    end else begin
      r_State    <= w_State_Nx;
      r_Cyc      <= w_Cyc_Nx;
      r_Bit      <= w_Bit_Nx;
      r_Pix      <= w_Pix_Nx;
      r_Shift    <= w_Shift_Nx;
      r_Prefetch <= w_Prefetch_Nx;
      r_Lat      <= w_Lat_Nx;
      r_Led      <= w_Led_Nx;
      r_Ready    <= w_Ready_Nx;
      r_Done     <= w_Done_Nx;
    end
  end

  // Next-state logic; o_Led is registered from the next bit position so it
  // rises on the very edge that leaves LOAD.
  always_comb begin
    w_State_Nx    = r_State;
    w_Cyc_Nx      = r_Cyc;
    w_Bit_Nx      = r_Bit;
    w_Pix_Nx      = r_Pix;
    w_Shift_Nx    = r_Shift;
    w_Prefetch_Nx = r_Prefetch;
    w_Lat_Nx      = r_Lat;
    w_Done_Nx     = 1'b0;
    w_Led_Nx      = 1'b0;
    w_Ready_Nx    = 1'b0;
    case (r_State)
      IDLE: begin
        if (bus.i_Start) w_State_Nx = LOAD;
        else             w_State_Nx = IDLE;
      end
      LOAD: begin
        w_Shift_Nx = w_Load_Pixel;
        w_Cyc_Nx   = '0;
        w_Bit_Nx   = 5'd0;
        w_Pix_Nx   = '0;
        w_State_Nx = BIT;
      end
      BIT: begin
        // Next pixel is captured on the first cycle of bit 23 only.
        if (r_Bit == 5'd23 && r_Cyc == '0 && r_Pix != PIX_LAST) w_Prefetch_Nx = w_Fetch_Pixel;
        else                                                    w_Prefetch_Nx = r_Prefetch;
        if (r_Cyc == BIT_LAST) begin
          w_Cyc_Nx = '0;
          if (r_Bit != 5'd23) begin
            w_Bit_Nx   = r_Bit + 5'd1;
            w_Shift_Nx = {r_Shift[22:0], 1'b0};
          end else if (r_Pix != PIX_LAST) begin
            w_Bit_Nx   = 5'd0;
            w_Pix_Nx   = w_Pix_Inc;
            w_Shift_Nx = r_Prefetch;
          end else begin
            w_Bit_Nx   = 5'd0;
            w_Lat_Nx   = '0;
            w_State_Nx = LATCH;
          end
        end else begin
          w_Cyc_Nx = r_Cyc + CW'(1'b1);
        end
      end
      LATCH: begin
        if (r_Lat == LAT_LAST) begin
          w_State_Nx = IDLE;
          w_Done_Nx  = 1'b1;
        end else begin
          w_Lat_Nx = r_Lat + LW'(1'b1);
        end
      end
      default: w_State_Nx = IDLE;
    endcase
    w_Led_Nx   = (w_State_Nx == BIT) && (w_Cyc_Nx < (w_Shift_Nx[23] ? T1H_V : T0H_V));
    w_Ready_Nx = (w_State_Nx == IDLE);
  end

  assign bus.o_Led   = r_Led;
  assign bus.o_Ready = r_Ready;
  assign bus.o_Done  = r_Done;
endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench for ws2812_chain: decodes o_Led pulse widths and compares
// them against a queue of expected high times pushed when pixels/starts are driven.
module tb_ws2812_chain;
  localparam int T0H = 40;
  localparam int T1H = 80;
  localparam int BITC = 125;
  localparam int RSTC = 8000;
  localparam int FRAME_BITS = 48;

  logic i_Clock = 1'b0;
  logic i_Reset;
  always #5 i_Clock = ~i_Clock;

  ws2812_chain_if #(.NUM_LEDS(2)) bus ();
  ws2812_chain_if #(.NUM_LEDS(3)) bus3 ();

  ws2812_chain #(.CLOCK_FREQUENCY(100000000), .NUM_LEDS(2)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .bus(bus));

  ws2812_chain #(.CLOCK_FREQUENCY(100000000), .NUM_LEDS(3), .T0H_NS(20), .T1H_NS(50),
                 .BIT_NS(80), .RESET_US(1)) dut3 (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .bus(bus3));

  int n_assert = 0;
  int n_fail = 0;
  int exp_q[$];
  logic [23:0] exp3_q[$];
  logic [23:0] mdl [2];
  logic [23:0] m3 [3];

  // monitor results, written only by the monitor process
  int obs_high [1024];
  int obs_per [1024];
  int obs_cnt = 0;
  int frame_gap [16];
  int frame_bits [16];
  int frame_base [16];
  int frame_cnt = 0;
  int ready_bad = 0;

  initial begin : monitor
    logic prev_led;
    bit   in_frame;
    int   since_rise, high_cnt, fr_cyc, fstart;
    prev_led = 1'b0; in_frame = 1'b0;
    since_rise = 0; high_cnt = 0; fr_cyc = 0; fstart = 0;
    forever begin
      @(negedge i_Clock);
      if (i_Reset) begin
        prev_led = 1'b0;
        in_frame = 1'b0;
      end else begin
        if (bus.o_Led && !prev_led) begin
          if (!in_frame) begin
            in_frame = 1'b1; fstart = obs_cnt; fr_cyc = 0;
          end else begin
            obs_per[obs_cnt-1] = since_rise; fr_cyc++;
          end
          obs_cnt++; since_rise = 1; high_cnt = 1;
        end else begin
          since_rise++;
          if (in_frame) fr_cyc++;
          if (bus.o_Led) high_cnt++;
          if (prev_led && !bus.o_Led) obs_high[obs_cnt-1] = high_cnt;
        end
        if (in_frame && bus.o_Ready && !bus.o_Done) ready_bad++;
        if (in_frame && bus.o_Done) begin
          frame_gap[frame_cnt] = fr_cyc;
          frame_bits[frame_cnt] = obs_cnt - fstart;
          frame_base[frame_cnt] = fstart;
          frame_cnt++;
          in_frame = 1'b0;
        end
        prev_led = bus.o_Led;
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge i_Clock); #1; end
  endtask

  task automatic wr(input logic [0:0] a, input logic [23:0] d);
    bus.i_Wr_En = 1'b1; bus.i_Wr_Addr = a; bus.i_Wr_Data = d;
    step(1);
    bus.i_Wr_En = 1'b0;
    mdl[a] = d;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [23:0] d);
    bus3.i_Wr_En = 1'b1; bus3.i_Wr_Addr = a; bus3.i_Wr_Data = d;
    step(1);
    bus3.i_Wr_En = 1'b0;
    if (a < 2'd3) m3[a] = d;
  endtask

  task automatic start();
    bus.i_Start = 1'b1;
    step(1);
    bus.i_Start = 1'b0;
  endtask

  task automatic push_frame();
    for (int p = 0; p < 2; p++)
      for (int b = 23; b >= 0; b--)
        exp_q.push_back(mdl[p][b] ? T1H : T0H);
  endtask

  task automatic check_frame(input int f);
    int budget, base, e;
    budget = 20000;
    while (frame_cnt <= f && budget > 0) begin step(1); budget--; end
    chk("frame_done_seen", frame_cnt > f, 1);
    base = frame_base[f];
    chk("frame_bits", frame_bits[f], FRAME_BITS);
    for (int k = 0; k < FRAME_BITS; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("f%0d_bit_high[%0d]", f, k), obs_high[base+k], e);
      if (k < FRAME_BITS - 1) chk($sformatf("f%0d_bit_period[%0d]", f, k), obs_per[base+k], BITC);
    end
    chk("first_rise_to_done", frame_gap[f], FRAME_BITS * BITC + RSTC);
    chk("done_high", bus.o_Done, 1);
    chk("ready_at_done", bus.o_Ready, 1);
    step(1);
    chk("done_one_cycle", bus.o_Done, 0);
  endtask

  task automatic run3(output logic [71:0] bits);
    int budget;
    bits = 72'd0;
    bus3.i_Start = 1'b1;
    step(1);
    bus3.i_Start = 1'b0;
    step(4);
    for (int k = 0; k < 72; k++) begin
      bits = {bits[70:0], bus3.o_Led};
      step(8);
    end
    budget = 400;
    while (!bus3.o_Done && budget > 0) begin step(1); budget--; end
    chk("dut3_done", bus3.o_Done, 1);
  endtask

  initial begin
    logic [71:0] bits3;
    int obs_snap;
    i_Reset = 1'b1;
    bus.i_Wr_En = 1'b0; bus.i_Wr_Addr = '0; bus.i_Wr_Data = 24'd0; bus.i_Start = 1'b0;
    bus3.i_Wr_En = 1'b0; bus3.i_Wr_Addr = '0; bus3.i_Wr_Data = 24'd0; bus3.i_Start = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    bus.i_Brightness = 8'hFF;
    bus3.i_Brightness = 8'hFF;
`endif
    step(3);
    chk("reset_led", bus.o_Led, 0);
    chk("reset_ready", bus.o_Ready, 1);
    chk("reset_done", bus.o_Done, 0);
    i_Reset = 1'b0;
    step(2);

    // frame 0: basic pattern, latency, ignored mid-frame start
    wr(1'b0, 24'hAA0000);
    wr(1'b1, 24'h000001);
    push_frame();
    start();
    chk("ready_drop_after_start", bus.o_Ready, 0);
    chk("led_low_in_load", bus.o_Led, 0);
    step(1);
    chk("first_rise_after_load", bus.o_Led, 1);
    step(100);
    start();
    check_frame(0);
    obs_snap = obs_cnt;
    step(20);
    chk("no_queued_frame_bits", obs_cnt, obs_snap);
    chk("idle_ready", bus.o_Ready, 1);
    chk("ready_low_during_frame", ready_bad, 0);

    // frame 1: write pixel 1 during pixel 0 bit 5 takes effect now
    wr(1'b0, 24'h123456);
    wr(1'b1, 24'hC3A55A);
    start();
    step(1 + BITC * 5 + 10);
    wr(1'b1, 24'hFFFFFF);
    push_frame();
    check_frame(1);

    // frame 2/3: write pixel 1 during its bit 10 only affects the next frame
    push_frame();
    start();
    step(1 + BITC * 34 + 10);
    wr(1'b1, 24'h0F0F0F);
    check_frame(2);
    push_frame();
    start();
    check_frame(3);

    // asynchronous reset during pixel 1
    start();
    step(1 + BITC * 30 + 10);
    chk("pre_reset_ready", bus.o_Ready, 0);
    chk("pre_reset_led", bus.o_Led, 1);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("async_reset_led", bus.o_Led, 0);
    chk("async_reset_ready", bus.o_Ready, 1);
    chk("async_reset_done", bus.o_Done, 0);
    step(2);
    i_Reset = 1'b0;
    step(1);
    wr(1'b0, 24'h00FF81);
    wr(1'b1, 24'h7E0018);
    push_frame();
    start();
    check_frame(4);

    // 3-LED instance: out-of-range address is ignored
    wr3(2'd0, 24'h5A5A5A);
    wr3(2'd1, 24'h0F00F0);
    wr3(2'd2, 24'hC00003);
    wr3(2'd3, 24'hFFFFFF);
    for (int p = 0; p < 3; p++) exp3_q.push_back(m3[p]);
    run3(bits3);
    chk("dut3_pixel0", bits3[71:48], exp3_q.pop_front());
    chk("dut3_pixel1", bits3[47:24], exp3_q.pop_front());
    chk("dut3_pixel2", bits3[23:0], exp3_q.pop_front());

`ifdef WS2812_BRIGHTNESS_EN
    step(2);
    bus3.i_Brightness = 8'h7F;
    wr3(2'd0, 24'hFF8040);
    exp3_q.push_back(24'h7F4020);
    run3(bits3);
    chk("dut3_brightness_pixel0", bits3[71:48], exp3_q.pop_front());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ws2812_chain.md
WS2812_CHAIN -- requirements
Module: ws2812_chain

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100000000, i_Clock frequency in Hz.
REQ-002 SHALL have parameter NUM_LEDS, default 8, LEDs in chain (>=1).
REQ-003 SHALL have parameter T0H_NS, default 400, high time of a 0 bit.
REQ-004 SHALL have parameter T1H_NS, default 800, high time of a 1 bit.
REQ-005 SHALL have parameter BIT_NS, default 1250, total bit period.
REQ-006 SHALL have parameter RESET_US, default 80, low latch time after a frame.
REQ-007 SHALL have port i_Clock  input  1  system clock.
REQ-008 SHALL have port i_Reset  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port i_Wr_En  input  1  pixel write strobe.
REQ-010 SHALL have port i_Wr_Addr  input  AW=max(1,clog2(NUM_LEDS))  pixel index.
REQ-011 SHALL have port i_Wr_Data  input  24  pixel colour, GRB order, G in [23:16].
REQ-012 SHALL have port i_Start  input  1  frame request.
REQ-013 SHALL have port o_Led  output  1  serial data to chain.
REQ-014 SHALL have port o_Ready  output  1  high when idle and able to accept i_Start.
REQ-015 SHALL have port o_Done  output  1  one-cycle pulse at frame end.

Function
REQ-016 SHALL derive cycle counts as X_CYC = CLOCK_FREQUENCY*X_NS/1e9 (integer truncation) for T0H, T1H and BIT, and RESET_CYC = CLOCK_FREQUENCY*RESET_US/1e6; everything runs in the i_Clock domain, with no derived clocks.
REQ-017 SHALL hold a NUM_LEDS x 24 pixel store; a write SHALL occur on any edge with i_Wr_En=1, in any state; addresses >= NUM_LEDS SHALL be ignored.
REQ-018 SHALL implement FSM states IDLE, LOAD, BIT, LATCH.
REQ-019 IDLE: o_Led=0, o_Ready=1; i_Start=1 SHALL go to LOAD and drop o_Ready on the next edge.
REQ-020 LOAD (one cycle): SHALL read pixel 0 into a 24-bit shift register and reset the bit and pixel counters.
REQ-021 BIT: each bit SHALL last exactly BIT_CYC cycles, with o_Led=1 for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then 0 for the rest; bits SHALL be sent MSB first, pixel 0 first.
REQ-022 The first o_Led rising edge SHALL occur on the edge following the LOAD cycle, i.e. 2 edges after i_Start is sampled.
REQ-023 The next pixel SHALL be fetched during bit 23 of the current pixel, with no gap between pixels; a write to that pixel after the first cycle of bit 23 SHALL apply to the next frame only.
REQ-024 Frame high/low length SHALL equal exactly NUM_LEDS*24*BIT_CYC cycles.
REQ-025 After the last bit of pixel NUM_LEDS-1, the FSM SHALL enter LATCH with o_Led=0 for RESET_CYC cycles, then return to IDLE with o_Done=1 for that one cycle.
REQ-026 i_Start outside IDLE SHALL be ignored and not queued; i_Start held high SHALL start a new frame on the first IDLE cycle.
REQ-027 Counters SHALL be sized from the parameters and SHALL never wrap within a frame.
REQ-028 Elaboration SHALL fail if T0H_CYC >= T1H_CYC, T1H_CYC >= BIT_CYC, or NUM_LEDS < 1.

Reset
REQ-029 i_Reset SHALL force, without a clock: FSM=IDLE, o_Led=0, o_Ready=1, o_Done=0, and all counters and the shift register to 0.
REQ-030 Reset mid-frame SHALL abort the frame immediately, with o_Led low.
REQ-031 Pixel store contents SHALL NOT be required to survive reset or be cleared by it.

Configuration
REQ-032 Macro WS2812_BRIGHTNESS_EN defined: the block SHALL add port i_Brightness input 8; each colour byte c SHALL be sent as (c*(i_Brightness+1))>>8, with i_Brightness sampled in LOAD and held for the frame.
REQ-033 Macro WS2812_BRIGHTNESS_EN undefined: the port SHALL be absent and bytes SHALL be sent unscaled.

Verification (CLOCK_FREQUENCY=100000000, NUM_LEDS=2, defaults: T0H=40, T1H=80, BIT=125, RESET=8000 cycles)
REQ-034 Write addr0=0xAA0000, addr1=0x000001, then pulse i_Start -> 48 bits of 125 cycles each: bits 23..16 high for 80/40/80/40..., last bit high 80; o_Done pulses 6000+8000 cycles after the first rising edge.
REQ-035 Pulse i_Start 100 cycles into a frame -> ignored; exactly one frame is sent; o_Ready=0 throughout the frame and LATCH.
REQ-036 Write addr1=0xFFFFFF during bit 5 of pixel 0 -> new value is sent in this frame; write addr1 during pixel 1 bit 10 -> current frame unchanged, next frame uses the new value.
REQ-037 Assert i_Reset during pixel 1 -> o_Led=0 and o_Ready=1 without a clock edge; a later i_Start sends a full frame.
REQ-038 Write to addr 3 (>= NUM_LEDS) -> no pixel changes.
REQ-039 With WS2812_BRIGHTNESS_EN, i_Brightness=0x7F and pixel 0xFF8040 -> sent as 0x7F4020.
